// File: rtl/xpar_target.sv
// Responder for the xtop parallel bus: small register map bridging CPU accesses to TX/RX byte FIFOs.
// Optional macro XPAR_IRQ_EN adds the IEN register (address 4) and a registered irq output.
module xpar_target #(
  parameter int DATA_W    = 32,
  parameter int PADDR_W   = 8,
  parameter int STRM_W    = 8,
  parameter int FIFO_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0]  par_wdata,
  input  logic               par_we,
  input  logic               par_re,
  output logic [DATA_W-1:0]  par_rdata,
  output logic [STRM_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [STRM_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready
`ifdef XPAR_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CNT_W = FIFO_LOG2 + 1;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_TXDATA = 3'd1;
  localparam logic [2:0] A_RXDATA = 3'd2;
  localparam logic [2:0] A_LEVEL  = 3'd3;
  localparam logic [2:0] A_IEN    = 3'd4;

  logic [2:0] addr;
  logic       wr_en, rd_en;

  logic [STRM_W-1:0]    tx_mem [DEPTH];
  logic [STRM_W-1:0]    rx_mem [DEPTH];
  logic [FIFO_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CNT_W-1:0]     tx_cnt, rx_cnt;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic                 tx_push, tx_pop, rx_push, rx_pop;
  logic                 tx_ovf, rx_unf, tx_ovf_set, rx_unf_set;
  logic                 tx_ovf_clr, rx_unf_clr;
  logic [DATA_W-1:0]    status, level, rdata_sel;

  logic unused_bits;
  assign unused_bits = ^{par_addr[PADDR_W-1:3], par_wdata[DATA_W-1:STRM_W]};

  assign addr  = par_addr[2:0];
  assign wr_en = par_we;
  // a simultaneous write takes the cycle; the read returns 0 and has no side effects
  assign rd_en = par_re & ~par_we;

  assign tx_full  = (tx_cnt == CNT_W'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CNT_W'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rp];
  assign rx_ready = rst & ~rx_full;

  assign tx_push    = wr_en & (addr == A_TXDATA) & ~tx_full;
  assign tx_ovf_set = wr_en & (addr == A_TXDATA) & tx_full;
  assign tx_pop     = tx_valid & tx_ready;
  assign rx_push    = rx_valid & rx_ready;
  assign rx_pop     = rd_en & (addr == A_RXDATA) & ~rx_empty;
  assign rx_unf_set = rd_en & (addr == A_RXDATA) & rx_empty;
  assign tx_ovf_clr = wr_en & (addr == A_STATUS) & par_wdata[4];
  assign rx_unf_clr = wr_en & (addr == A_STATUS) & par_wdata[5];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= par_wdata[STRM_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      tx_cnt <= tx_cnt + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_cnt <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
      // a new error event in the clearing cycle keeps the flag set
      tx_ovf <= tx_ovf_set | (tx_ovf & ~tx_ovf_clr);
      rx_unf <= rx_unf_set | (rx_unf & ~rx_unf_clr);
    end
  end

`ifdef XPAR_IRQ_EN
  logic [2:0] ien;
  logic [2:0] irq_cond;

  assign irq_cond = {tx_ovf | rx_unf, tx_empty, ~rx_empty};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ien <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_en && addr == A_IEN) ien <= par_wdata[2:0];
      irq <= |(ien & irq_cond);
    end
  end
`endif

  always_comb begin
    status    = '0;
    status[0] = tx_full;
    status[1] = tx_empty;
    status[2] = rx_full;
    status[3] = rx_empty;
    status[4] = tx_ovf;
    status[5] = rx_unf;
    level       = '0;
    level[7:0]  = 8'(tx_cnt);
    level[15:8] = 8'(rx_cnt);
  end

  always_comb begin
    rdata_sel = '0;
    case (addr)
      A_STATUS: rdata_sel = status;
      A_RXDATA: rdata_sel = rx_empty ? '0 : DATA_W'(rx_mem[rx_rp]);
      A_LEVEL:  rdata_sel = level;
`ifdef XPAR_IRQ_EN
      A_IEN:    rdata_sel = DATA_W'(ien);
`endif
      default:  rdata_sel = '0;
    endcase
    par_rdata = rd_en ? rdata_sel : '0;
  end

endmodule
